ysyx_25040129_csr_ctrl: RTL and testbench
=========================================

# ysyx_25040129_csr_ctrl

Multi-cycle CSR access controller sitting between the execute stage and the machine-mode CSR register file. It accepts one Zicsr / ECALL / MRET operation at a time over a valid/ready handshake, sequences the register file's read port, write port and trap pulses, and returns the old CSR value plus any PC redirect to the pipeline. It is the initiator side of the CSR file interface: it drives the file's address, data, write-enable, ecall/mret and mepc/mcause inputs, and consumes its `csr_out` and `target_from_csr`.

## Interface
- `MCAUSE_ECALL`, default 32'd11: cause code written on ECALL (environment call from M-mode).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: the pipeline presents an operation.
- `req_ready` output 1: the controller can accept; high only in IDLE.
- `req_funct3` input 3: Zicsr funct3. 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `req_csr` input 12: CSR address.
- `req_rs1` input 32: rs1 value.
- `req_uimm` input 5: rs1 field, used as the zimm for the I-forms and for the write-suppress check.
- `req_pc` input 32: PC of the operation.
- `req_ecall`, `req_mret` input 1 each: trap-type operation; overrides funct3.
- `resp_valid` output 1: a response is held.
- `resp_ready` input 1: the pipeline consumes the response.
- `resp_rdata` output 32: old CSR value; 0 for traps and illegal ops.
- `resp_redirect` output 1: the pipeline must jump to `resp_target`.
- `resp_target` output 32: redirect PC.
- `resp_illegal` output 1: funct3 was 000 or 100 with no trap flag.
- `csr_read_addr`, `csr_write_addr` output 12: CSR file addresses.
- `csr_data` output 32: write data.
- `csr_write`, `ecall`, `mret` output 1: single-cycle pulses to the CSR file.
- `mepc_data`, `mcause_data` output 32: trap write data.
- `csr_out` input 32: combinational read data from the CSR file.
- `target_from_csr` input 32: trap target, registered inside the CSR file.

## Operation
- **States:** IDLE, READ, WRITE, TRAP, TGT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch all `req_*` fields.
  - If `req_ecall` → TRAP (ECALL has priority when both trap flags are set).
  - Otherwise → READ.
- **READ:**
  - Drive `csr_read_addr` = latched address (0x341 for MRET).
  - Capture `csr_out` into `old`.
  - For MRET → TRAP; otherwise → WRITE.
- **WRITE:** compute `src` = `rs1` for funct3[2]=0, or {27'b0, `uimm`} for funct3[2]=1.
  - RW/RWI: `new` = `src`.
  - RS/RSI: `new` = `old | src`.
  - RC/RCI: `new` = `old & ~src`.
  - Pulse `csr_write` with `csr_write_addr`=address and `csr_data`=`new`, except in two cases:
    - RS/RC/RSI/RCI with `uimm`==0 (no write).
    - Illegal funct3 (no write, `resp_illegal`=1, `resp_rdata`=0).
  - → RESP with `resp_rdata`=`old` and `resp_redirect`=0.
- **TRAP:** pulse exactly one of `ecall` / `mret` for one cycle → TGT.
  - ECALL: `mepc_data`=`pc`, `mcause_data`=`MCAUSE_ECALL`.
  - MRET: `mepc_data`=`old` (the captured mepc), so mepc is rewritten unchanged.
- **TGT:** latch `target_from_csr` into `resp_target`, set `resp_redirect`=1 → RESP.
- **RESP:** `resp_valid`=1 with all `resp_*` held stable until `resp_ready`; on handshake → IDLE.
- While not in their active state:
  - `csr_write`, `ecall` and `mret` are 0.
  - `csr_read_addr` holds its last value.
  - `mepc_data` and `mcause_data` are 0.

## Timing
- **Reset:**
  - All state returns to IDLE immediately, including mid-operation; any in-flight pulse is dropped.
  - Output values: `req_ready`=1.
  - All `resp_*` are 0.
  - All CSR-side outputs are 0.
- **Zicsr latency:** accept at edge 0, READ in cycle 1, WRITE pulse in cycle 2, `resp_valid` from cycle 3.
- **ECALL latency:** pulse in cycle 1, TGT in cycle 2, `resp_valid` in cycle 3.
- **MRET latency:** READ in cycle 1, pulse in cycle 2, TGT in cycle 3, `resp_valid` in cycle 4.
- **Pulse width:** each `csr_write` / `ecall` / `mret` pulse is exactly one cycle, and at most one is asserted per operation.
- **Throughput:** the next request can be accepted no earlier than the cycle after the `resp` handshake.
- **Back-to-back:** the write from operation N is visible to the READ of operation N+1.

## Test plan
- **CSRRW:** mtvec=0 after reset, CSRRW 0x305 with rs1=0x8000_0100 → `resp_rdata`=0, one `csr_write` pulse with data 0x8000_0100. A following CSRRS 0x305 with uimm=0 → `resp_rdata`=0x8000_0100 and no `csr_write`.
- **CSRRS / CSRRCI:** mstatus=0x0000_1800, CSRRS rs1=0x8 → `csr_data`=0x1808. Then CSRRCI uimm=0x8 → `resp_rdata`=0x1808, `csr_data`=0x1800.
- **ECALL:** mtvec=0x8000_0100, ECALL at pc=0x8000_0040 → one `ecall` pulse with `mepc_data`=0x8000_0040 and `mcause_data`=11. Response has `resp_redirect`=1, `resp_target`=0x8000_0100, `resp_valid` in cycle 3.
- **MRET:** then MRET → READ of 0x341, `mret` pulse with `mepc_data`=0x8000_0040, `resp_target`=0x8000_0040, mepc unchanged afterwards.
- **Backpressure / illegal funct3:** hold `resp_ready`=0 for 5 cycles → `resp_*` stable and `req_ready`=0. Separately, funct3=100 → `resp_illegal`=1, no write pulse.
- **Reset in WRITE:** assert `rst` while in WRITE → `csr_write` drops asynchronously, `req_ready`=1 after release, and no response is issued.

Source files
------------

// File: rtl/ysyx_25040129_csr_ctrl.sv
// ysyx_25040129_csr_ctrl
// ----------------------
// Multi-cycle controller between the execute stage and the machine-mode CSR
// register file. It accepts one Zicsr / ECALL / MRET operation at a time and
// sequences the CSR file's read port, write port and trap pulses. It then
// returns the old CSR value and any PC redirect to the pipeline.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   req_*               : operation request (valid/ready handshake)
//   resp_*              : operation response (valid/ready handshake)
//   csr_read_addr       : CSR file read address (held between operations)
//   csr_write_addr,
//   csr_data, csr_write : CSR file write port (csr_write is a 1-cycle pulse)
//   ecall, mret         : 1-cycle trap pulses to the CSR file
//   mepc_data,
//   mcause_data         : trap write data, 0 outside the trap pulse
//   csr_out             : combinational read data from the CSR file
//   target_from_csr     : trap target, registered inside the CSR file
//
// All outputs are registered. Each pulse is loaded on the edge that enters
// its state, so the pulse is high for exactly that state's cycle.
module ysyx_25040129_csr_ctrl #(
  parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_rs1,
  input  logic [4:0]  req_uimm,
  input  logic [31:0] req_pc,
  input  logic        req_ecall,
  input  logic        req_mret,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_redirect,
  output logic [31:0] resp_target,
  output logic        resp_illegal,
  output logic [11:0] csr_read_addr,
  output logic [11:0] csr_write_addr,
  output logic [31:0] csr_data,
  output logic        csr_write,
  output logic        ecall,
  output logic        mret,
  output logic [31:0] mepc_data,
  output logic [31:0] mcause_data,
  input  logic [31:0] csr_out,
  input  logic [31:0] target_from_csr
);

  localparam logic [11:0] CSR_MEPC = 12'h341;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_TRAP  = 3'd3,
    S_TGT   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t      state_r;
  logic [2:0]  funct3_r;
  logic [11:0] csr_r;
  logic [31:0] rs1_r;
  logic [4:0]  uimm_r;
  logic        is_mret_r;
  logic [31:0] old_r;

  logic [31:0] src_s;
  logic [31:0] new_s;
  logic        illegal_s;
  logic        no_write_s;

  // New CSR value, computed from the live read data while leaving READ.
  always_comb begin
    src_s      = funct3_r[2] ? {27'd0, uimm_r} : rs1_r;
    new_s      = 32'd0;
    illegal_s  = (funct3_r[1:0] == 2'b00);
    // Set/clear forms with a zero rs1 field must not touch the CSR.
    no_write_s = illegal_s || (funct3_r[1] && (uimm_r == 5'd0));
    case (funct3_r[1:0])
      2'b01:   new_s = src_s;
      2'b10:   new_s = csr_out | src_s;
      2'b11:   new_s = csr_out & ~src_s;
      default: new_s = 32'd0;
    endcase
  end

  // Operation sequencer with registered handshake, CSR-side and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      funct3_r       <= 3'd0;
      csr_r          <= 12'd0;
      rs1_r          <= 32'd0;
      uimm_r         <= 5'd0;
      is_mret_r      <= 1'b0;
      old_r          <= 32'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'd0;
      resp_redirect  <= 1'b0;
      resp_target    <= 32'd0;
      resp_illegal   <= 1'b0;
      csr_read_addr  <= 12'd0;
      csr_write_addr <= 12'd0;
      csr_data       <= 32'd0;
      csr_write      <= 1'b0;
      ecall          <= 1'b0;
      mret           <= 1'b0;
      mepc_data      <= 32'd0;
      mcause_data    <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            funct3_r  <= req_funct3;
            csr_r     <= req_csr;
            rs1_r     <= req_rs1;
            uimm_r    <= req_uimm;
            // ECALL wins when both trap flags are set.
            is_mret_r <= req_mret && !req_ecall;
            req_ready <= 1'b0;
            if (req_ecall) begin
              ecall       <= 1'b1;
              mepc_data   <= req_pc;
              mcause_data <= MCAUSE_ECALL;
              state_r     <= S_TRAP;
            end else begin
              csr_read_addr <= req_mret ? CSR_MEPC : req_csr;
              state_r       <= S_READ;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_READ: begin
          old_r <= csr_out;
          if (is_mret_r) begin
            // Rewrite mepc with its own value during the MRET pulse.
            mret      <= 1'b1;
            mepc_data <= csr_out;
            state_r   <= S_TRAP;
          end else begin
            if (!no_write_s) begin
              csr_write      <= 1'b1;
              csr_write_addr <= csr_r;
              csr_data       <= new_s;
            end else begin
              csr_write <= 1'b0;
            end
            state_r <= S_WRITE;
          end
        end

        S_WRITE: begin
          csr_write     <= 1'b0;
          resp_valid    <= 1'b1;
          resp_rdata    <= illegal_s ? 32'd0 : old_r;
          resp_illegal  <= illegal_s;
          resp_redirect <= 1'b0;
          resp_target   <= 32'd0;
          state_r       <= S_RESP;
        end

        S_TRAP: begin
          ecall       <= 1'b0;
          mret        <= 1'b0;
          mepc_data   <= 32'd0;
          mcause_data <= 32'd0;
          state_r     <= S_TGT;
        end

        S_TGT: begin
          // The CSR file has registered its target by now.
          resp_target   <= target_from_csr;
          resp_redirect <= 1'b1;
          resp_rdata    <= 32'd0;
          resp_illegal  <= 1'b0;
          resp_valid    <= 1'b1;
          state_r       <= S_RESP;
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_r    <= S_IDLE;
          end else begin
            resp_valid <= 1'b1;
          end
        end

        default: begin
          csr_write   <= 1'b0;
          ecall       <= 1'b0;
          mret        <= 1'b0;
          mepc_data   <= 32'd0;
          mcause_data <= 32'd0;
          resp_valid  <= 1'b0;
          req_ready   <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_csr_ctrl.sv
// Testbench for ysyx_25040129_csr_ctrl. A small behavioural CSR file
// (mstatus, mtvec, mepc, mcause) sits on the CSR side. A vector table drives
// operations; each expected record goes into a scoreboard queue when its
// request is driven and is popped when the response appears.
module tb_ysyx_25040129_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [31:0] req_rs1;
  logic [4:0]  req_uimm;
  logic [31:0] req_pc;
  logic        req_ecall;
  logic        req_mret;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_target;
  logic        resp_illegal;
  logic [11:0] csr_read_addr;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_data;
  logic        csr_write;
  logic        ecall;
  logic        mret;
  logic [31:0] mepc_data;
  logic [31:0] mcause_data;
  logic [31:0] csr_out;
  logic [31:0] target_from_csr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25040129_csr_ctrl #(.MCAUSE_ECALL(32'd11)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr(req_csr), .req_rs1(req_rs1), .req_uimm(req_uimm), .req_pc(req_pc),
    .req_ecall(req_ecall), .req_mret(req_mret),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_redirect(resp_redirect), .resp_target(resp_target), .resp_illegal(resp_illegal),
    .csr_read_addr(csr_read_addr), .csr_write_addr(csr_write_addr), .csr_data(csr_data),
    .csr_write(csr_write), .ecall(ecall), .mret(mret),
    .mepc_data(mepc_data), .mcause_data(mcause_data),
    .csr_out(csr_out), .target_from_csr(target_from_csr)
  );

  // Behavioural CSR file
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_tgt;

  always_comb begin
    case (csr_read_addr)
      12'h300: csr_out = m_mstatus;
      12'h305: csr_out = m_mtvec;
      12'h341: csr_out = m_mepc;
      12'h342: csr_out = m_mcause;
      default: csr_out = 32'd0;
    endcase
  end
  assign target_from_csr = m_tgt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mstatus <= 32'd0; m_mtvec <= 32'd0; m_mepc <= 32'd0;
      m_mcause <= 32'd0; m_tgt <= 32'd0;
    end else begin
      if (csr_write) begin
        case (csr_write_addr)
          12'h300: m_mstatus <= csr_data;
          12'h305: m_mtvec   <= csr_data;
          12'h341: m_mepc    <= csr_data;
          12'h342: m_mcause  <= csr_data;
          default: ;
        endcase
      end
      if (ecall) begin
        m_mepc <= mepc_data; m_mcause <= mcause_data; m_tgt <= m_mtvec;
      end
      if (mret) begin
        m_mepc <= mepc_data; m_tgt <= m_mepc;
      end
    end
  end

  typedef struct {
    logic        ec;
    logic        mr;
    logic [2:0]  f3;
    logic [11:0] csr;
    logic [31:0] rs1;
    logic [4:0]  uimm;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] tgt;
    logic        ill;
    int          nwr;
    logic [31:0] wdata;
    logic [31:0] mepc;
    int          lat;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];

  function automatic vec_t mk(input logic ec, input logic mr, input logic [2:0] f3,
                              input logic [11:0] csr, input logic [31:0] rs1,
                              input logic [4:0] uimm, input logic [31:0] pc,
                              input logic [31:0] rdata, input logic redir,
                              input logic [31:0] tgt, input logic ill, input int nwr,
                              input logic [31:0] wdata, input logic [31:0] mepc,
                              input int lat);
    vec_t v;
    v.ec = ec; v.mr = mr; v.f3 = f3; v.csr = csr; v.rs1 = rs1; v.uimm = uimm;
    v.pc = pc; v.rdata = rdata; v.redir = redir; v.tgt = tgt; v.ill = ill;
    v.nwr = nwr; v.wdata = wdata; v.mepc = mepc; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    vec_t e;
    int wr_n = 0, ec_n = 0, mr_n = 0, lat = 0, rdy_hi = 0, mepc_leak = 0;
    logic [31:0] wdata = 32'd0, mepc_o = 32'd0, mcause_o = 32'd0;
    logic [11:0] waddr = 12'd0, raddr = 12'd0;
    sb_q.push_back(v);
    @(negedge clk);
    req_valid = 1'b1; req_ecall = v.ec; req_mret = v.mr; req_funct3 = v.f3;
    req_csr = v.csr; req_rs1 = v.rs1; req_uimm = v.uimm; req_pc = v.pc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) raddr = csr_read_addr;
      if (req_ready) rdy_hi++;
      if (csr_write) begin wr_n++; wdata = csr_data; waddr = csr_write_addr; end
      if (ecall) begin ec_n++; mepc_o = mepc_data; mcause_o = mcause_data; end
      if (mret) begin mr_n++; mepc_o = mepc_data; end
      if (!ecall && !mret && (mepc_data != 32'd0 || mcause_data != 32'd0)) mepc_leak++;
      if (resp_valid) begin lat = c; break; end
    end
    e = sb_q.pop_front();
    chk("latency", lat, e.lat);
    chk("resp_rdata", resp_rdata, e.rdata);
    chk("resp_redirect", {31'd0, resp_redirect}, {31'd0, e.redir});
    if (e.redir) chk("resp_target", resp_target, e.tgt);
    chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, e.ill});
    chk("write_pulses", wr_n, e.nwr);
    if (e.nwr != 0) begin
      chk("csr_data", wdata, e.wdata);
      chk("csr_write_addr", {20'd0, waddr}, {20'd0, e.csr});
    end
    chk("ecall_pulses", ec_n, {31'd0, e.ec});
    chk("mret_pulses", mr_n, {31'd0, e.mr & ~e.ec});
    if (e.ec || e.mr) chk("mepc_data", mepc_o, e.mepc);
    if (e.ec) chk("mcause_data", mcause_o, 32'd11);
    if (!e.ec) chk("csr_read_addr", {20'd0, raddr}, {20'd0, e.mr ? 12'h341 : e.csr});
    chk("req_ready_busy", rdy_hi, 0);
    chk("mepc_idle_zero", mepc_leak, 0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("resp_valid_after", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stable_bad;
    int rv_seen;
    logic [31:0] held;
    vecs[0]  = mk(1'b0, 1'b0, 3'b001, 12'h305, 32'h8000_0100, 5'd1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1, 32'h8000_0100, 32'd0, 3);
    vecs[1]  = mk(1'b0, 1'b0, 3'b010, 12'h305, 32'd0, 5'd0, 32'd0, 32'h8000_0100, 1'b0, 32'd0, 1'b0, 0, 32'd0, 32'd0, 3);
    vecs[2]  = mk(1'b0, 1'b0, 3'b001, 12'h300, 32'h0000_1800, 5'd5, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1, 32'h0000_1800, 32'd0, 3);
    vecs[3]  = mk(1'b0, 1'b0, 3'b010, 12'h300, 32'h0000_0008, 5'd3, 32'd0, 32'h0000_1800, 1'b0, 32'd0, 1'b0, 1, 32'h0000_1808, 32'd0, 3);
    vecs[4]  = mk(1'b0, 1'b0, 3'b111, 12'h300, 32'd0, 5'd8, 32'd0, 32'h0000_1808, 1'b0, 32'd0, 1'b0, 1, 32'h0000_1800, 32'd0, 3);
    vecs[5]  = mk(1'b1, 1'b0, 3'b000, 12'h000, 32'd0, 5'd0, 32'h8000_0040, 32'd0, 1'b1, 32'h8000_0100, 1'b0, 0, 32'd0, 32'h8000_0040, 3);
    vecs[6]  = mk(1'b0, 1'b1, 3'b000, 12'h000, 32'd0, 5'd0, 32'h8000_0044, 32'd0, 1'b1, 32'h8000_0040, 1'b0, 0, 32'd0, 32'h8000_0040, 4);
    vecs[7]  = mk(1'b0, 1'b0, 3'b010, 12'h341, 32'd0, 5'd0, 32'd0, 32'h8000_0040, 1'b0, 32'd0, 1'b0, 0, 32'd0, 32'd0, 3);
    vecs[8]  = mk(1'b0, 1'b0, 3'b100, 12'h300, 32'hFFFF_FFFF, 5'd7, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 0, 32'd0, 32'd0, 3);
    vecs[9]  = mk(1'b0, 1'b0, 3'b101, 12'h342, 32'd0, 5'h1F, 32'd0, 32'd11, 1'b0, 32'd0, 1'b0, 1, 32'h0000_001F, 32'd0, 3);
    vecs[10] = mk(1'b0, 1'b0, 3'b110, 12'h342, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'h0000_001F, 1'b0, 32'd0, 1'b0, 0, 32'd0, 32'd0, 3);
    vecs[11] = mk(1'b0, 1'b0, 3'b101, 12'h305, 32'd0, 5'd0, 32'd0, 32'h8000_0100, 1'b0, 32'd0, 1'b0, 1, 32'd0, 32'd0, 3);
    vecs[12] = mk(1'b0, 1'b0, 3'b011, 12'h300, 32'h0000_0800, 5'd2, 32'd0, 32'h0000_1800, 1'b0, 32'd0, 1'b0, 1, 32'h0000_1000, 32'd0, 3);
    vecs[13] = mk(1'b1, 1'b1, 3'b000, 12'h000, 32'd0, 5'd0, 32'h0000_1234, 32'd0, 1'b1, 32'd0, 1'b0, 0, 32'd0, 32'h0000_1234, 3);

    rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_csr = 12'd0; req_rs1 = 32'd0;
    req_uimm = 5'd0; req_pc = 32'd0; req_ecall = 1'b0; req_mret = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_pulses", {29'd0, csr_write, ecall, mret}, 32'd0);
    chk("reset_read_addr", {20'd0, csr_read_addr}, 32'd0);
    chk("reset_trap_data", mepc_data | mcause_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_op(vecs[i]);

    // Backpressure: response must hold steady while resp_ready stays low.
    @(negedge clk);
    req_valid = 1'b1; req_ecall = 1'b0; req_mret = 1'b0; req_funct3 = 3'b010;
    req_csr = 12'h300; req_rs1 = 32'd0; req_uimm = 5'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 10 && rv_seen == 0; c++) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1;
    end
    chk("bp_resp_valid", rv_seen, 1);
    held = resp_rdata;
    chk("bp_rdata", held, 32'h0000_1000);
    stable_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!resp_valid || req_ready || resp_rdata != held || resp_redirect || resp_illegal)
        stable_bad++;
    end
    chk("bp_stable", stable_bad, 0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("bp_release", {31'd0, req_ready}, 32'd1);

    // Reset while the write pulse is on the wire.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr = 12'h305;
    req_rs1 = 32'h0000_ABCD; req_uimm = 5'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("rst_write_before", {31'd0, csr_write}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_write_async", {31'd0, csr_write}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    chk("rst_no_resp", rv_seen, 0);
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
    run_op(mk(1'b0, 1'b0, 3'b001, 12'h300, 32'h0000_0055, 5'd4, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1, 32'h0000_0055, 32'd0, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
